unidade_busca: RTL and testbench
================================

# unidade_busca

Instruction fetch and field-split unit that feeds the opcode and register/immediate fields to the main control decoder and datapath. It owns the program counter and runs a memory read handshake to fetch one 32-bit MIPS instruction at a time. It presents the instruction for at least one cycle, then advances the PC using the decoder's branch/jump decision and the ALU zero flag. It sits between instruction memory and the control/decode stage.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0.
- clock  in  1  system clock, rising-edge active.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  out  32  instruction address (= pc).
- mem_req  out  1  read request, held until acknowledged.
- mem_ack  in  1  memory acknowledge; mem_data is valid in the same cycle.
- mem_data  in  32  instruction word from memory.
- stall  in  1  datapath not ready; holds the unit in ISSUE.
- branch  in  1  Branch control from the decoder.
- zero  in  1  ALU zero flag.
- jump  in  1  jump control (opcode 000010 decoded).
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- funct  out  6  instr[5:0].
- imm  out  16  instr[15:0].
- pc_plus4  out  32  pc + 4 of the current instruction.
- instr_valid  out  1  instr/fields valid for the decoder.
- instr_count  out  32  number of instructions retired.

## Operation

- States: IDLE, FETCH, ISSUE, UPDATE.
- Reset values (asynchronous):
  - state = IDLE
  - pc = RESET_PC & ~3
  - instr = 0
  - instr_count = 0
  - mem_req = 0
  - instr_valid = 0
- Transitions:
  - IDLE -> FETCH: unconditional.
  - FETCH -> ISSUE: when mem_ack = 1. The same edge captures instr <= mem_data. Otherwise the unit stays in FETCH.
  - ISSUE -> UPDATE: when stall = 0. With stall = 1 the unit stays in ISSUE and instr is held.
  - UPDATE -> FETCH: unconditional. The PC is loaded with next_pc and instr_count increments.
- Moore outputs:
  - mem_req = (state == FETCH).
  - instr_valid = (state == ISSUE).
  - mem_addr = pc at all times.
- Field outputs are continuous slices of instr.
- next_pc priority:
  - jump = 1 -> {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch & zero -> pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}).
  - else pc_plus4.
- All address arithmetic is modulo 2^32:
  - pc 32'hFFFF_FFFC gives pc_plus4 = 0.
  - Branch targets wrap silently.
- branch, zero and jump are sampled only on the UPDATE edge and ignored in all other states.
- mem_ack outside FETCH is ignored; mem_data is not captured.
- instr_count wraps from 32'hFFFF_FFFF to 0.

## Timing

- Zero-wait memory (ack in the first FETCH cycle): 3 cycles per instruction, FETCH -> ISSUE -> UPDATE.
- Each memory wait cycle adds 1 cycle in FETCH. mem_addr is stable for the whole request.
- instr_valid rises in the cycle after the ack edge. It lasts 1 + (number of stall cycles).
- The decoder's outputs settle within ISSUE; branch/jump must be valid by the UPDATE edge.
- First request: mem_req rises 1 cycle after reset_n deasserts (IDLE cycle).
- Reset asserted mid-fetch or mid-issue:
  - mem_req and instr_valid drop immediately (asynchronously).
  - A pending ack is discarded.
  - pc returns to RESET_PC.
- Stall asserted in FETCH has no effect. Stall is evaluated only in ISSUE.

## Test plan

- Reset with RESET_PC = 32'h0000_0040, zero-wait ack, sequential non-branch words:
  - mem_addr sequence is 0x40, 0x44, 0x48.
  - instr_valid pulses 1 cycle out of every 3.
  - instr_count = 3 after the third UPDATE.
- Fetch 32'h8C22_0010 (lw) with ack delayed 2 cycles:
  - mem_req stays high 3 cycles at a stable address.
  - Then opcode = 6'b100011, rs = 1, rt = 2, imm = 16'h0010.
- At pc = 0x100, instruction beq with imm = 16'hFFFE:
  - branch = 1, zero = 1 -> next mem_addr = 0x0FC.
  - Same case with zero = 0 -> next mem_addr = 0x104.
- At pc = 0x1000_0008, instruction 32'h0800_0010 with jump = 1 -> next mem_addr = 0x1000_0040.
- Stall held 4 cycles in ISSUE:
  - instr_valid is high 5 cycles and instr is unchanged.
  - pc does not advance until stall drops.
- reset_n pulsed low while in FETCH with mem_ack arriving the same cycle:
  - instr = 0, mem_req = 0, pc = RESET_PC.
  - After release the fetch restarts at RESET_PC.
- PC wrap: pc = 32'hFFFF_FFFC with a non-branch instruction -> next mem_addr = 0.

Source files
------------

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch FSM that owns the PC, runs the memory read
// handshake and splits the fetched MIPS word into decoder fields.
module unidade_busca #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic [31:0] instr_count
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, UPDATE} state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      state_q;
    logic [31:0] pc_q, pc_d, instr_q, count_q;
    logic        mem_req_q, valid_q;

    assign mem_addr    = pc_q;
    assign mem_req     = mem_req_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_count = count_q;
    assign opcode      = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign funct       = instr_q[5:0];
    assign imm         = instr_q[15:0];
    assign pc_plus4    = pc_q + 32'd4;

    // Jump outranks a taken branch; all targets wrap modulo 2^32.
    always_comb begin
        pc_d = jump           ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
               branch && zero ? pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00} :
                                pc_plus4;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= PC_INIT;
            instr_q   <= '0;
            count_q   <= '0;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q   <= FETCH;
                    mem_req_q <= 1'b1;
                end
                FETCH: if (mem_ack) begin
                    state_q   <= ISSUE;
                    instr_q   <= mem_data;
                    mem_req_q <= 1'b0;
                    valid_q   <= 1'b1;
                end
                ISSUE: if (!stall) begin
                    state_q <= UPDATE;
                    valid_q <= 1'b0;
                end
                UPDATE: begin
                    state_q   <= FETCH;
                    pc_q      <= pc_d;
                    count_q   <= count_q + 32'd1;
                    mem_req_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: vector table of fetch/branch/jump/stall cases plus reset and
// randomized instruction streams checked against a PC/count reference model.
module tb_unidade_busca;
    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        clock = 1'b0, reset_n = 1'b1, mem_ack = 1'b0, stall = 1'b0;
    logic        branch = 1'b0, zero = 1'b0, jump = 1'b0;
    logic [31:0] mem_data = '0;
    logic [31:0] mem_addr, instr, pc_plus4, instr_count;
    logic        mem_req, instr_valid;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    int checks = 0, failures = 0;
    logic [31:0] m_pc, m_cnt;

    unidade_busca #(.RESET_PC(RPC)) dut (
        .clock(clock), .reset_n(reset_n), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_data(mem_data), .stall(stall), .branch(branch),
        .zero(zero), .jump(jump), .instr(instr), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .funct(funct), .imm(imm), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] w;
        int          waits;
        int          stalls;
        logic        br, z, j;
        logic [31:0] nxt;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic noise();
        branch = 1'($urandom);
        zero   = 1'($urandom);
        jump   = 1'($urandom);
    endtask

    // Next PC straight from the architectural rules: word-index jump, scaled signed offset, or +4.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic br, input logic z, input logic j);
        logic [31:0]        p4;
        logic signed [31:0] off;
        p4  = pc + 32'd4;
        off = $signed(w[15:0]);
        if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (br && z) return p4 + 32'(off * 4);
        return p4;
    endfunction

    // Entered at a negedge while the DUT is in FETCH; leaves at the negedge after the PC update.
    task automatic run_instr(input logic [31:0] w, input int waits, input int stalls,
                             input logic br, input logic z, input logic j);
        logic [31:0] p;
        p = m_pc;
        chk("req_fetch", {31'b0, mem_req}, 32'd1);
        chk("addr_fetch", mem_addr, p);
        for (int i = 0; i < waits; i++) begin
            mem_ack = 1'b0; mem_data = $urandom; stall = 1'($urandom); noise();
            step();
            chk("req_wait", {31'b0, mem_req}, 32'd1);
            chk("addr_stable", mem_addr, p);
            chk("valid_wait", {31'b0, instr_valid}, 32'd0);
        end
        mem_ack = 1'b1; mem_data = w; stall = 1'($urandom);
        step();
        mem_ack = 1'b0; mem_data = $urandom;
        chk("valid_issue", {31'b0, instr_valid}, 32'd1);
        chk("req_issue", {31'b0, mem_req}, 32'd0);
        chk("instr", instr, w);
        chk("opcode", {26'b0, opcode}, {26'b0, w[31:26]});
        chk("rs", {27'b0, rs}, {27'b0, w[25:21]});
        chk("rt", {27'b0, rt}, {27'b0, w[20:16]});
        chk("rd", {27'b0, rd}, {27'b0, w[15:11]});
        chk("funct", {26'b0, funct}, {26'b0, w[5:0]});
        chk("imm", {16'b0, imm}, {16'b0, w[15:0]});
        chk("pc_plus4", pc_plus4, p + 32'd4);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1; mem_ack = 1'($urandom); noise();
            step();
            chk("valid_stall", {31'b0, instr_valid}, 32'd1);
            chk("instr_stall", instr, w);
            chk("addr_stall", mem_addr, p);
        end
        stall = 1'b0; mem_ack = 1'b0; branch = br; zero = z; jump = j;
        step();
        chk("valid_update", {31'b0, instr_valid}, 32'd0);
        chk("req_update", {31'b0, mem_req}, 32'd0);
        chk("addr_update", mem_addr, p);
        mem_ack = 1'b1; mem_data = ~w;
        step();
        mem_ack = 1'b0;
        m_pc  = ref_next(p, w, br, z, j);
        m_cnt = m_cnt + 32'd1;
        chk("next_addr", mem_addr, m_pc);
        chk("count", instr_count, m_cnt);
        chk("instr_hold", instr, w);
        noise();
    endtask

    initial begin
        tbl = '{
            '{32'h2001_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'd1},
            '{32'h0000_0020, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0048, 32'd2},
            '{32'h8C22_0010, 2, 0, 1'b0, 1'b0, 1'b0, 32'h0000_004C, 32'd3},
            '{32'h0800_0040, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'd4},
            '{32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'd5},
            '{32'h0800_0040, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'd6},
            '{32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_00FC, 32'd7},
            '{32'h0000_0020, 0, 4, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'd8},
            '{32'h0BFF_FFFC, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0FFF_FFF0, 32'd9},
            '{32'h1000_0005, 0, 0, 1'b1, 1'b1, 1'b0, 32'h1000_0008, 32'd10},
            '{32'h0800_0010, 0, 0, 1'b0, 1'b0, 1'b1, 32'h1000_0040, 32'd11},
            '{32'h1000_FFEB, 0, 1, 1'b1, 1'b1, 1'b0, 32'h0FFF_FFF0, 32'd12},
            '{32'h0800_0000, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'd13},
            '{32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'd14},
            '{32'h0000_0020, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd15},
            '{32'h0800_0010, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'd16}
        };
        #2 reset_n = 1'b0;
        #1;
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_addr", mem_addr, RPC);
        step(); step();
        reset_n = 1'b1;
        #1 chk("idle_req", {31'b0, mem_req}, 32'd0);
        step();
        chk("first_req", {31'b0, mem_req}, 32'd1);
        m_pc = RPC; m_cnt = '0;

        for (int k = 0; k < 16; k++) begin
            run_instr(tbl[k].w, tbl[k].waits, tbl[k].stalls, tbl[k].br, tbl[k].z, tbl[k].j);
            chk("tbl_addr", mem_addr, tbl[k].nxt);
            chk("tbl_count", instr_count, tbl[k].cnt);
        end

        // Reset lands in FETCH on the same cycle as an ack: the word must be discarded.
        mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_addr", mem_addr, RPC);
        chk("mid_rst_count", instr_count, 32'd0);
        step();
        mem_ack = 1'b0; reset_n = 1'b1;
        #1 chk("mid_idle_req", {31'b0, mem_req}, 32'd0);
        step();
        chk("restart_req", {31'b0, mem_req}, 32'd1);
        chk("restart_addr", mem_addr, RPC);
        chk("restart_instr", instr, 32'd0);
        m_pc = RPC; m_cnt = '0;

        for (int k = 0; k < 40; k++)
            run_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      1'($urandom), 1'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
